// File: rtl/rr_arb_4ch.sv
// Four-channel round-robin arbiter feeding a single-entry registered output stage.
// Optional burst locking is enabled by defining RR_ARB_LOCK_EN.
module rr_arb_4ch #(
  parameter int W   = 4,
  parameter int NCH = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [NCH-1:0] in_valid,
  input  logic [NCH*W-1:0] in_data,
`ifdef RR_ARB_LOCK_EN
  input  logic [NCH-1:0] in_last,
`endif
  output logic [NCH-1:0] in_ready,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [W-1:0]   out_data,
  output logic [1:0]     out_sel,
  output logic [NCH-1:0] grant
);

  logic           out_valid_reg;
  logic [W-1:0]   out_data_reg;
  logic [1:0]     out_sel_reg;
  logic [1:0]     ptr_reg;

  logic           can_load;
  logic           xfer;
  logic [1:0]     base;
  logic [2*NCH-1:0] req_dbl;
  logic [NCH-1:0] req_rot;
  logic [NCH-1:0] gnt_rot;
  logic [2*NCH-1:0] gnt_dbl;
  logic [NCH-1:0] rr_grant;
  logic [1:0]     win_idx;

  assign can_load = !out_valid_reg || out_ready;

  // Rotate requests so the channel after ptr sits at bit 0, take the lowest set
  // bit, then rotate the one-hot result back into channel order.
  assign base    = ptr_reg + 2'd1;
  assign req_dbl = {in_valid, in_valid} >> base;
  assign req_rot = req_dbl[NCH-1:0];
  assign gnt_rot = req_rot & (~req_rot + {{(NCH-1){1'b0}}, 1'b1});
  assign gnt_dbl = {gnt_rot, gnt_rot} << base;
  assign rr_grant = gnt_dbl[2*NCH-1:NCH];

`ifdef RR_ARB_LOCK_EN
  typedef enum logic {ARB, LOCKED} state_t;
  state_t     state_reg, state_next;
  logic [1:0] lock_ch_reg, lock_ch_next;
  logic       ptr_upd;

  always_comb begin
    grant = rr_grant;
    if (state_reg == LOCKED) begin
      grant = '0;
      grant[lock_ch_reg] = in_valid[lock_ch_reg];
    end
  end
`else
  assign grant = rr_grant;
`endif

  always_comb begin
    win_idx = 2'd0;
    for (int i = 0; i < NCH; i++) begin
      if (grant[i]) win_idx = 2'(i);
    end
  end

  // The reset cycle never accepts anything, even though grant stays visible.
  assign in_ready = grant & {NCH{can_load && !rst}};
  assign xfer     = |(in_valid & in_ready);

`ifdef RR_ARB_LOCK_EN
  always_comb begin
    state_next   = state_reg;
    lock_ch_next = lock_ch_reg;
    ptr_upd      = 1'b0;
    case (state_reg)
      ARB: begin
        if (xfer) begin
          ptr_upd = 1'b1;
          if (!in_last[win_idx]) begin
            state_next   = LOCKED;
            lock_ch_next = win_idx;
          end
        end
      end
      LOCKED: begin
        if (xfer && in_last[lock_ch_reg]) begin
          state_next = ARB;
          ptr_upd    = 1'b1;
        end
      end
      default: state_next = ARB;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= ARB;
      lock_ch_reg <= 2'd0;
    end else begin
      state_reg   <= state_next;
      lock_ch_reg <= lock_ch_next;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_reg <= 1'b0;
      out_data_reg  <= '0;
      out_sel_reg   <= 2'd0;
      ptr_reg       <= 2'd3;
    end else if (xfer) begin
      out_valid_reg <= 1'b1;
      out_data_reg  <= in_data[win_idx*W +: W];
      out_sel_reg   <= win_idx;
`ifdef RR_ARB_LOCK_EN
      if (ptr_upd) ptr_reg <= win_idx;
`else
      ptr_reg       <= win_idx;
`endif
    end else if (out_valid_reg && out_ready) begin
      out_valid_reg <= 1'b0;
    end
  end

  assign out_valid = out_valid_reg;
  assign out_data  = out_data_reg;
  assign out_sel   = out_sel_reg;

endmodule

// File: tb/tb_rr_arb_4ch.sv
// Self-checking bench for rr_arb_4ch: directed scenarios plus random traffic
// compared every cycle against a queue-free round-robin reference model.
module tb_rr_arb_4ch;

  logic        clk;
  logic        rst;
  logic [3:0]  in_valid;
  logic [15:0] in_data;
  logic [3:0]  in_ready;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  out_data;
  logic [1:0]  out_sel;
  logic [3:0]  grant;
`ifdef RR_ARB_LOCK_EN
  logic [3:0]  in_last;
`endif

  int checks = 0;
  int errors = 0;

  // Reference model state
  bit       m_valid;
  int       m_data;
  int       m_sel;
  int       m_ptr;

  rr_arb_4ch #(.W(4), .NCH(4)) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_data(in_data),
`ifdef RR_ARB_LOCK_EN
    .in_last(in_last),
`endif
    .in_ready(in_ready),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_data),
    .out_sel(out_sel),
    .grant(grant)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: compare DUT against the model mid-cycle, then advance the model.
  task automatic cycle();
    logic [3:0] eg;
    int         w;
    int         c;
    bit         cl;
    @(negedge clk);
    eg = 4'b0;
    w  = -1;
    for (int k = 1; k <= 4; k++) begin
      c = (m_ptr + k) % 4;
      if (w < 0 && in_valid[c]) begin
        w = c;
        eg[c] = 1'b1;
      end
    end
    cl = !m_valid || out_ready;
    check("grant", {28'b0, grant}, {28'b0, eg});
    check("in_ready", {28'b0, in_ready}, (cl && !rst) ? {28'b0, eg} : 32'b0);
    check("out_valid", {31'b0, out_valid}, {31'b0, m_valid});
    check("out_data", {28'b0, out_data}, 32'(m_data));
    check("out_sel", {30'b0, out_sel}, 32'(m_sel));
    if (rst) begin
      m_valid = 0; m_data = 0; m_sel = 0; m_ptr = 3;
    end else if (w >= 0 && cl) begin
      m_valid = 1;
      m_data  = int'(in_data[w*4 +: 4]);
      m_sel   = w;
      m_ptr   = w;
    end else if (m_valid && out_ready) begin
      m_valid = 0;
    end
    @(posedge clk);
    #1;
    $display("cyc rst=%0b v=%b rdy=%b gnt=%b -> out_valid=%0b sel=%0d data=%0h",
             rst, in_valid, out_ready, eg, out_valid, out_sel, out_data);
  endtask

  initial begin
    rst = 1'b1; in_valid = 4'b0; in_data = 16'h0; out_ready = 1'b0;
`ifdef RR_ARB_LOCK_EN
    in_last = 4'hF;
`endif
    @(posedge clk); #1;
    m_valid = 0; m_data = 0; m_sel = 0; m_ptr = 3;
    cycle();
    rst = 1'b0;
    check("reset_valid", {31'b0, out_valid}, 32'd0);
    check("reset_sel", {30'b0, out_sel}, 32'd0);

    // All channels requesting: strict rotation 0,1,2,3,...
    in_valid = 4'b1111; in_data = 16'h4321; out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      cycle();
      check("rot_sel", {30'b0, out_sel}, 32'(i % 4));
      check("rot_data", {28'b0, out_data}, 32'(i % 4 + 1));
    end

    // Only odd channels: 1,3,1,3 and even channels never accepted
    in_valid = 4'b1010;
    for (int i = 0; i < 4; i++) begin
      cycle();
      check("odd_sel", {30'b0, out_sel}, (i % 2 == 0) ? 32'd1 : 32'd3);
      check("odd_even_ready", {28'b0, in_ready & 4'b0101}, 32'd0);
    end

    // Walk to out_sel=2 then stall three cycles
    in_valid = 4'b1111;
    for (int i = 0; i < 3; i++) cycle();
    check("pre_stall_sel", {30'b0, out_sel}, 32'd2);
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cycle();
      check("stall_ready", {28'b0, in_ready}, 32'd0);
      check("stall_sel", {30'b0, out_sel}, 32'd2);
      check("stall_data", {28'b0, out_data}, 32'd3);
    end
    out_ready = 1'b1;
    #1;
    check("release_ready", {28'b0, in_ready}, 32'b1000);
    cycle();
    check("release_sel", {30'b0, out_sel}, 32'd3);
    check("release_valid", {31'b0, out_valid}, 32'd1);

    // Bring ptr to 1 with a held word, then reset mid-stream
    cycle();
    cycle();
    check("prereset_sel", {30'b0, out_sel}, 32'd1);
    rst = 1'b1;
    #1;
    check("reset_cycle_ready", {28'b0, in_ready}, 32'd0);
    cycle();
    rst = 1'b0;
    check("midreset_valid", {31'b0, out_valid}, 32'd0);
    check("midreset_data", {28'b0, out_data}, 32'd0);
    check("midreset_sel", {30'b0, out_sel}, 32'd0);
    #1;
    check("post_reset_grant", {28'b0, grant}, 32'b0001);

    // ch1 wins, idle five cycles, then ch2 must win
    cycle();
    cycle();
    check("idle_pre_sel", {30'b0, out_sel}, 32'd1);
    in_valid = 4'b0000;
    for (int i = 0; i < 5; i++) cycle();
    check("idle_drained", {31'b0, out_valid}, 32'd0);
    in_valid = 4'b1111;
    cycle();
    check("idle_resume_sel", {30'b0, out_sel}, 32'd2);

    // Random traffic against the model
    for (int i = 0; i < 400; i++) begin
      in_valid  = 4'($urandom);
      in_data   = 16'($urandom);
      out_ready = ($urandom % 4) != 0;
      rst       = ($urandom % 50) == 0;
      cycle();
    end
    rst = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
